// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared defaults and types for the return-address-stack controller
package ras_pkg;
    localparam int DEF_STACK_DEPTH = 8;
    localparam int DEF_ENTRY_SIZE  = 64;
    localparam int DEF_NUM_CKPT    = 8;
    localparam int TAIL_W          = $clog2(DEF_STACK_DEPTH);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ras_state_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [TAIL_W-1:0] tail;
    } ckpt_entry_t;
endpackage

// File: rtl/ras_ckpt_buf.sv
// rtl/ras_ckpt_buf.sv - circular checkpoint buffer: allocate, resolve, squash younger, free oldest
module ras_ckpt_buf
    import ras_pkg::*;
#(
    parameter int NUM_CKPT = DEF_NUM_CKPT
) (
    input  logic                        clk_in,
    input  logic                        rst_N_in,
    input  logic                        alloc,
    input  logic [TAIL_W-1:0]           alloc_tail,
    input  logic                        resolve_valid,
    input  logic                        resolve_mispredict,
    input  logic [$clog2(NUM_CKPT)-1:0] resolve_tag,
    output logic [$clog2(NUM_CKPT)-1:0] alloc_ptr,
    output logic                        full,
    output logic                        mis_hit,
    output logic [TAIL_W-1:0]           mis_tail
);
    localparam int CW = $clog2(NUM_CKPT);

    ckpt_entry_t         ckpt [NUM_CKPT];
    logic [CW-1:0]       free_ptr;
    logic [CW-1:0]       t_age;
    logic [NUM_CKPT-1:0] valid_vec;
    logic                tag_valid;
    logic                do_resolve;
    logic                do_free;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_CKPT; i++) valid_vec[i] = ckpt[i].valid;
    end

    // Valid entries are contiguous from free_ptr, so the slot at alloc_ptr is valid only when full.
    assign full       = valid_vec[alloc_ptr];
    assign tag_valid  = valid_vec[resolve_tag];
    assign mis_hit    = resolve_valid && resolve_mispredict && tag_valid;
    assign do_resolve = resolve_valid && !resolve_mispredict && tag_valid;
    assign mis_tail   = ckpt[resolve_tag].tail;
    assign do_free    = ckpt[free_ptr].valid && ckpt[free_ptr].done;
    assign t_age      = resolve_tag - free_ptr;

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            alloc_ptr <= '0;
            free_ptr  <= '0;
            for (int i = 0; i < NUM_CKPT; i++) ckpt[i] <= '0;
        end else begin
            if (do_free) begin
                ckpt[free_ptr].valid <= 1'b0;
                free_ptr             <= free_ptr + 1'b1;
            end
            if (do_resolve) ckpt[resolve_tag].done <= 1'b1;
            if (mis_hit) begin
                ckpt[resolve_tag].done <= 1'b1;
                // Age is distance from the oldest entry; anything older-in-age than t is younger than t.
                for (int i = 0; i < NUM_CKPT; i++) begin
                    if ((CW'(i) - free_ptr) > t_age) ckpt[i].valid <= 1'b0;
                end
                alloc_ptr <= resolve_tag + 1'b1;
            end else if (alloc) begin
                ckpt[alloc_ptr] <= '{valid: 1'b1, done: 1'b0, tail: alloc_tail};
                alloc_ptr       <= alloc_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - speculative return-stack controller: push/pop on fetch, tail restore on mispredict
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int ENTRY_SIZE  = DEF_ENTRY_SIZE,
    parameter int NUM_CKPT    = DEF_NUM_CKPT
) (
    input  logic                           clk_in,
    input  logic                           rst_N_in,
    input  logic                           fetch_valid,
    input  logic                           fetch_is_call,
    input  logic                           fetch_is_ret,
    input  logic                           fetch_is_cond,
    input  logic [ENTRY_SIZE-1:0]          fetch_pc,
    output logic                           fetch_ready,
    output logic [$clog2(NUM_CKPT)-1:0]    fetch_tag,
    input  logic                           resolve_valid,
    input  logic                           resolve_mispredict,
    input  logic [$clog2(NUM_CKPT)-1:0]    resolve_tag,
    output logic                           push,
    output logic                           pop,
    output logic                           restoreTail,
    output logic [ENTRY_SIZE-1:0]          pushee,
    output logic [$clog2(STACK_DEPTH)-1:0] newTail,
    input  logic [ENTRY_SIZE-1:0]          stack_top,
    output logic [ENTRY_SIZE-1:0]          pred_target,
    output logic                           pred_valid
);
    localparam int TW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(NUM_CKPT);

    ras_state_t    state, state_nxt;
    logic [TW-1:0] spec_tail, recover_tail, mis_tail;
    logic [CW-1:0] alloc_ptr;
    logic          ctl, ckpt_full, accept, mis_hit;

    assign ctl = fetch_is_call || fetch_is_ret || fetch_is_cond;

    ras_ckpt_buf #(.NUM_CKPT(NUM_CKPT)) u_buf (
        .clk_in             (clk_in),
        .rst_N_in           (rst_N_in),
        .alloc              (accept && ctl),
        .alloc_tail         (spec_tail),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .resolve_tag        (resolve_tag),
        .alloc_ptr          (alloc_ptr),
        .full               (ckpt_full),
        .mis_hit            (mis_hit),
        .mis_tail           (mis_tail)
    );

    // Stack-facing outputs are gated by reset so nothing leaks while the pipeline is being cleared.
    always_comb begin
        state_nxt   = state;
        restoreTail = 1'b0;
        newTail     = '0;
        fetch_ready = (state == RUN) && !resolve_mispredict && !(ctl && ckpt_full);
        accept      = rst_N_in && fetch_valid && fetch_ready;
        push        = accept && fetch_is_call;
        pop         = accept && fetch_is_ret;
        pred_valid  = accept && fetch_is_ret;
        case (state)
            RUN: begin
                if (mis_hit) state_nxt = RECOVER;
            end
            RECOVER: begin
                restoreTail = rst_N_in;
                newTail     = rst_N_in ? recover_tail : '0;
                state_nxt   = mis_hit ? RECOVER : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign pushee      = fetch_pc + ENTRY_SIZE'(4);
    assign pred_target = stack_top;
    assign fetch_tag   = rst_N_in ? alloc_ptr : '0;

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state        <= RUN;
            spec_tail    <= '0;
            recover_tail <= '0;
        end else begin
            state <= state_nxt;
            if (mis_hit) recover_tail <= mis_tail;
            if (state == RECOVER)    spec_tail <= recover_tail;
            else if (push && !pop)   spec_tail <= spec_tail + 1'b1;
            else if (pop && !push)   spec_tail <= spec_tail - 1'b1;
        end
    end
endmodule
